// File: rtl/sysctrl_pkg.sv
// Shared definitions for the system-control host: command codes, responder
// magic bytes and the host FSM state encoding.
package sysctrl_pkg;

  localparam logic [7:0] CMD_STATUS  = 8'd0;
  localparam logic [7:0] CMD_LEDS    = 8'd1;
  localparam logic [7:0] CMD_COLOR   = 8'd2;
  localparam logic [7:0] CMD_BUTTONS = 8'd3;
  localparam logic [7:0] CMD_CONFIG  = 8'd4;
  localparam logic [7:0] CMD_INT     = 8'd5;
  localparam logic [7:0] CMD_INTSRC  = 8'd6;
  localparam logic [7:0] CMD_PORT    = 8'd7;
  localparam logic [7:0] CMD_MENU    = 8'd8;

  localparam logic [7:0] MAGIC0 = 8'h5C;
  localparam logic [7:0] MAGIC1 = 8'h42;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CMD     = 3'd1;
  localparam state_t ST_GAP     = 3'd2;
  localparam state_t ST_WAIT_TX = 3'd3;
  localparam state_t ST_STROBE  = 3'd4;
  localparam state_t ST_FINISH  = 3'd5;

endpackage

// File: rtl/sysctrl_host.sv
// Byte-strobed host for the system-control responder: sends a command byte
// then req_len payload bytes, returning one response byte per payload byte.
module sysctrl_host
  import sysctrl_pkg::*;
#(
  parameter int GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [3:0] req_len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       done,
  output logic       busy,
  output logic       bus_strobe,
  output logic       bus_start,
  output logic [7:0] bus_data,
  input  logic [7:0] bus_data_out,
  input  logic       bus_int_n,
  output logic       irq
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

  state_t     state;
  logic [3:0] rem;
  logic [7:0] gap_cnt;
  logic       cap_pend;

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign tx_ready   = (state == ST_WAIT_TX);
  assign bus_strobe = (state == ST_CMD) || (state == ST_STROBE);
  assign bus_start  = (state == ST_CMD);
  assign done       = (state == ST_FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rem      <= '0;
      gap_cnt  <= '0;
      cap_pend <= 1'b0;
      bus_data <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq      <= ~bus_int_n;
      // Responder output is sampled the clock after a payload strobe.
      rx_valid <= cap_pend;
      cap_pend <= 1'b0;
      if (cap_pend) rx_data <= bus_data_out;

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            bus_data <= req_cmd;
            rem      <= req_len;
            state    <= ST_CMD;
          end
        end
        // With nothing left to send the trailing gap is cut to one clock so
        // done lands on the final response (or strobe+2 for empty payloads).
        ST_CMD: begin
          gap_cnt <= (rem != '0) ? GAP_LOAD : '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= (rem != '0) ? ST_WAIT_TX : ST_FINISH;
          else               gap_cnt <= gap_cnt - 8'd1;
        end
        ST_WAIT_TX: begin
          if (tx_valid) begin
            bus_data <= tx_data;
            state    <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          rem      <= rem - 4'd1;
          cap_pend <= 1'b1;
          gap_cnt  <= (rem != 4'd1) ? GAP_LOAD : '0;
          state    <= ST_GAP;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysctrl_host.sv
// Bench for sysctrl_host paired with a behavioural system-control responder;
// expected responses go into a scoreboard queue checked by a monitor.
module tb_sysctrl_host;
  import sysctrl_pkg::*;

  localparam int GAP_P = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_cmd = '0;
  logic [3:0] req_len = '0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       done;
  logic       busy;
  logic       bus_strobe;
  logic       bus_start;
  logic [7:0] bus_data;
  logic [7:0] bus_data_out;
  logic       bus_int_n = 1'b1;
  logic       irq;

  sysctrl_host #(.GAP(GAP_P)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_len(req_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .done(done), .busy(busy),
    .bus_strobe(bus_strobe), .bus_start(bus_start), .bus_data(bus_data),
    .bus_data_out(bus_data_out), .bus_int_n(bus_int_n), .irq(irq)
  );

  always #5 clk = ~clk;

  // Responder model: status returns magic bytes, color stores bit-reversed
  // bytes and echoes them, config echoes and "D" selects the floppy count.
  logic [7:0]  r_cmd, r_cfg_sel, r_floppy;
  logic [3:0]  r_idx;
  logic [23:0] r_color;

  function automatic logic [7:0] bitrev(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bitrev[i] = b[7-i];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      r_cmd <= '0; r_idx <= '0; r_cfg_sel <= '0; r_floppy <= '0;
      r_color <= '0; bus_data_out <= '0;
    end else if (bus_strobe) begin
      if (bus_start) begin
        r_cmd <= bus_data;
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + 4'd1;
        case (r_cmd)
          CMD_STATUS: bus_data_out <= (r_idx == 4'd0) ? MAGIC0 : (r_idx == 4'd1) ? MAGIC1 : 8'h00;
          CMD_COLOR: begin
            if (r_idx == 4'd0) r_color[7:0]   <= bitrev(bus_data);
            if (r_idx == 4'd1) r_color[15:8]  <= bitrev(bus_data);
            if (r_idx == 4'd2) r_color[23:16] <= bitrev(bus_data);
            bus_data_out <= bitrev(bus_data);
          end
          CMD_CONFIG: begin
            if (r_idx == 4'd0) r_cfg_sel <= bus_data;
            else if (r_cfg_sel == 8'h44) r_floppy <= bus_data;
            bus_data_out <= bus_data;
          end
          default: bus_data_out <= ~bus_data;
        endcase
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int last_strobe_cyc = -100;
  bit prev_strobe = 1'b0;
  bit expect_start = 1'b0;

  typedef struct packed { logic rx; logic [7:0] data; logic dn; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: strobe width, spacing, start marking, tx_ready gating.
  always @(negedge clk) begin
    if (!reset) begin
      chk("tx_ready_when_idle", 32'(tx_ready && !busy), 0);
      chk("start_without_strobe", 32'(bus_start && !bus_strobe), 0);
      if (bus_strobe) begin
        strobes++;
        chk("strobe_width", 32'(prev_strobe), 0);
        if (expect_start) begin
          chk("first_strobe_start", 32'(bus_start), 1);
          expect_start = 1'b0;
        end else begin
          chk("strobe_spacing_ok", 32'(cyc - last_strobe_cyc >= GAP_P + 1), 1);
        end
        last_strobe_cyc = cyc;
      end
      prev_strobe = bus_strobe;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (rx_valid || done)) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: rx_valid=%0b done=%0b rx_data=%0h", rx_valid, done, rx_data);
      end else begin
        e = exp_q.pop_front();
        chk("rx_valid", 32'(rx_valid), 32'(e.rx));
        if (e.rx) chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("done_coincident", 32'(done), 32'(e.dn));
      end
      if (done) chk("done_at_strobe_plus2", cyc, last_strobe_cyc + 2);
    end
  end

  task automatic issue(input logic [7:0] cmd, input logic [3:0] len, input bit intrude);
    expect_start = 1'b1;
    req_valid = 1'b1; req_cmd = cmd; req_len = len;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (intrude) begin
      req_cmd = CMD_BUTTONS; req_valid = 1'b1;
      repeat (3) begin @(negedge clk); chk("req_ready_while_busy", 32'(req_ready), 0); end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int n;
    int s0;
    if (stall > 0) begin
      repeat (2) @(posedge clk);
      s0 = strobes;
      repeat (stall - 2) @(posedge clk);
      #1;
      chk("no_strobe_in_stall", strobes, s0);
      chk("tx_ready_in_stall", 32'(tx_ready), 1);
    end
    tx_valid = 1'b1; tx_data = b; n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (tx_ready) break;
      n++;
    end
    chk("tx_handshake", 32'(tx_ready), 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int nstrobe, input int s_start);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 300);
    chk("done_seen", 32'(done), 1);
    chk("strobe_count", strobes - s_start, nstrobe);
    @(negedge clk);
    chk("req_ready_after_done", 32'(req_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic [7:0] cmd, input int len,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                         input int stall_idx, input int stall, input bit intrude);
    logic [7:0] bs[3];
    logic [7:0] es[3];
    int s_start;
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    es[0] = e0; es[1] = e1; es[2] = e2;
    s_start = strobes;
    if (len == 0) exp_q.push_back('{1'b0, 8'h00, 1'b1});
    for (int k = 0; k < len; k++) exp_q.push_back('{1'b1, es[k], (k == len - 1)});
    issue(cmd, 4'(len), intrude);
    for (int k = 0; k < len; k++) send_byte(bs[k], (k == stall_idx) ? stall : 0);
    wait_done(len + 1, s_start);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bus_strobe", 32'(bus_strobe), 0);
    chk("rst_bus_start", 32'(bus_start), 0);
    chk("rst_bus_data", 32'(bus_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_irq", 32'(irq), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int s_abort;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs();
    @(posedge clk); #1;

    run_txn(CMD_STATUS, 3, 8'h00, 8'h00, 8'h00, 8'h5C, 8'h42, 8'h00, -1, 0, 1'b0);
    run_txn(CMD_COLOR,  3, 8'h80, 8'h40, 8'hC0, 8'h01, 8'h02, 8'h03, -1, 0, 1'b0);
    chk("responder_color", 32'(r_color), 32'h030201);
    run_txn(CMD_LEDS,   0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1, 0, 1'b0);
    run_txn(CMD_CONFIG, 2, 8'h44, 8'h03, 8'h00, 8'h44, 8'h03, 8'h00, 1, 20, 1'b0);
    chk("responder_floppy", 32'(r_floppy), 3);

    // Abort: reset lands the clock after the second payload strobe.
    s_abort = strobes;
    exp_q.push_back('{1'b1, 8'h5C, 1'b0});
    issue(CMD_STATUS, 4'd3, 1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check_reset_outputs();
    chk("abort_strobes_before", strobes - s_abort, 3);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_more_strobes", strobes - s_abort, 3);
    chk("abort_queue_drained", exp_q.size(), 0);

    run_txn(CMD_STATUS, 3, 8'h00, 8'h00, 8'h00, 8'h5C, 8'h42, 8'h00, -1, 0, 1'b0);
    run_txn(CMD_PORT,   1, 8'h5A, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, -1, 0, 1'b1);

    bus_int_n = 1'b0;
    @(negedge clk); chk("irq_latency", 32'(irq), 0);
    @(negedge clk); chk("irq_set", 32'(irq), 1);
    @(posedge clk); #1 bus_int_n = 1'b1;
    @(negedge clk); chk("irq_hold", 32'(irq), 1);
    @(negedge clk); chk("irq_clear", 32'(irq), 0);

    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysctrl_host.md
SYSCTRL_HOST -- requirements
Module: sysctrl_host

Interface
REQ-001 Parameter GAP, default 4, idle clocks after each bus strobe; legal range 2..255.
REQ-002 clk  in  1  system clock; reset  in  1  synchronous, active-high reset.
REQ-003 req_valid  in  1  transaction request.
REQ-004 req_ready  out  1  host idle, request accepted when req_valid & req_ready.
REQ-005 req_cmd  in  8  command byte; req_len  in  4  payload byte count, 0..15.
REQ-006 tx_data  in  8  payload byte; tx_valid  in  1  byte offered; tx_ready  out  1  byte taken on tx_valid & tx_ready.
REQ-007 rx_data  out  8  response byte; rx_valid  out  1  one-clock pulse per response byte.
REQ-008 done  out  1  one-clock pulse at transaction end; busy  out  1  transaction in progress.
REQ-009 bus_strobe  out  1  byte strobe; bus_start  out  1  marks command byte; bus_data  out  8  byte to responder.
REQ-010 bus_data_out  in  8  responder reply byte; bus_int_n  in  1  responder interrupt, active-low; irq  out  1  registered inverse of bus_int_n.

Function
REQ-011 States: IDLE, CMD, GAP, WAIT_TX, STROBE, FINISH.
REQ-012 IDLE: req_ready=1, busy=0; on accept at cycle T, latch cmd/len, go to CMD.
REQ-013 CMD (T+1): bus_strobe=1, bus_start=1, bus_data=req_cmd; then GAP.
REQ-014 GAP: count GAP clocks with strobe low; on expiry go to WAIT_TX if bytes remain, else FINISH.
REQ-015 WAIT_TX: tx_ready=1; hold indefinitely while tx_valid=0, with no strobe and no timeout; on handshake latch byte, go to STROBE.
REQ-016 STROBE (cycle S): bus_strobe=1, bus_start=0, bus_data=latched byte; decrement remaining count; go to GAP.
REQ-017 Response capture: bus_data_out is sampled during S+1; rx_data holds that value and rx_valid=1 in S+2; exactly one rx byte per payload byte, none for the command byte.
REQ-018 Byte k's response = responder's data_out after payload byte k (CMD 0 byte 0 -> 0x5C).
REQ-019 bus_strobe is exactly one clock wide; strobe-to-strobe distance is at least GAP+1 clocks.
REQ-020 FINISH: done=1 for one clock, coincident with the final rx_valid, or at last-strobe+2 when req_len=0; IDLE next clock.
REQ-021 tx_ready=0 outside WAIT_TX; surplus tx bytes are not consumed.
REQ-022 req_valid while busy is ignored (req_ready=0) and is not queued.
REQ-023 bus_data holds its last value between strobes; bus_start=0 whenever bus_strobe=0.
REQ-024 irq follows bus_int_n with one-clock latency, independent of state.

Reset
REQ-025 Reset forces IDLE and sets outputs: req_ready=1 after release, bus_strobe=0, bus_start=0, bus_data=0, rx_valid=0, rx_data=0, done=0, busy=0, tx_ready=0, irq=0.
REQ-026 Reset mid-transaction aborts with no further strobe, rx_valid or done; the next accepted request starts with a bus_start strobe.

Structure
REQ-027 Shared package sysctrl_pkg holds command constants CMD_STATUS=0, CMD_LEDS=1, CMD_COLOR=2, CMD_BUTTONS=3, CMD_CONFIG=4, CMD_INT=5, CMD_INTSRC=6, CMD_PORT=7, CMD_MENU=8, magic bytes 0x5C/0x42, and the state enum.
REQ-028 Single module; the gap counter stays inline, so no sub-module is required.

Verification
REQ-029 Bench pairs the host with the system-control responder and GAP=4.
REQ-030 CMD 0, len 3, tx 00,00,00 -> rx 5C,42,00; done with third rx_valid; exactly 4 strobes, first with bus_start.
REQ-031 CMD 2, len 3, tx 80,40,C0 -> responder color = 0x030201; 3 rx_valid pulses; strobe spacing >= 5 clocks.
REQ-032 CMD 1, len 0 -> one start strobe, no rx_valid, done at strobe+2; req_ready high the next clock.
REQ-033 CMD 4, len 2, tx_valid withheld 20 clocks before the second byte -> no strobe during the stall; then responder system_floppy_drives updated per byte 2 ("D", 03 -> 3).
REQ-034 Reset asserted one clock after the second strobe of a len-3 transaction -> no further strobes/rx_valid/done; a following CMD 0 returns 5C,42,00.
REQ-035 Second req_valid during busy -> ignored; exactly one done; responder int_n low -> irq=1 one clock later.
